// File: rtl/sys_if_pkg.sv
// rtl/sys_if_pkg.sv - shared constants, state type and slot decode for the sys_if bridge
package sys_if_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int SLOT_MSB = 31;
  localparam int SLOT_LSB = 16;

  localparam int unsigned DEF_NUM_SLOTS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_RESP,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_e;

  function automatic logic slot_ok(input logic [15:0] slot, input int unsigned num_slots);
    return {16'h0, slot} < num_slots;
  endfunction

endpackage

// File: rtl/axil_sys_if_bridge_if.sv
// rtl/axil_sys_if_bridge_if.sv - AXI4-Lite host side and sys_if switch side of the bridge
interface axil_sys_if_bridge_if;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        sys_if_wen;
  logic [31:0] sys_if_addr;
  logic [31:0] sys_if_wdata;
  logic [31:0] sys_if_rdata;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, sys_if_rdata,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rvalid, sys_if_wen, sys_if_addr, sys_if_wdata
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, sys_if_rdata,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rvalid, sys_if_wen, sys_if_addr, sys_if_wdata
  );
endinterface

// File: rtl/axil_wr_hold.sv
// rtl/axil_wr_hold.sv - independent AW and W holding registers with their ready generation
module axil_wr_hold (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        aw_full,
  output logic        w_full,
  output logic [31:0] aw_addr_q,
  output logic [31:0] w_data_q,
  output logic [3:0]  w_strb_q
);

  assign awready = en && !aw_full && !rst;
  assign wready  = en && !w_full && !rst;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axil_sys_if_bridge.sv
// rtl/axil_sys_if_bridge.sv - AXI4-Lite slave driving the sys_if write strobe and held-address read
module axil_sys_if_bridge
  import sys_if_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int unsigned RD_WAIT   = 2
) (
  input logic                 clk,
  input logic                 rst,
  axil_sys_if_bridge_if.slave bus
);

  state_e      state, state_n;
  logic        aw_full, w_full;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        last_rd;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        idle, aw_take, w_take, wr_req, ar_take, hold_clear, addr_ok, wr_legal;

  axil_wr_hold u_wr_hold (
    .clk       (clk),
    .rst       (rst),
    .en        (idle),
    .clear     (hold_clear),
    .awaddr    (bus.s_axi_awaddr),
    .awvalid   (bus.s_axi_awvalid),
    .awready   (bus.s_axi_awready),
    .wdata     (bus.s_axi_wdata),
    .wstrb     (bus.s_axi_wstrb),
    .wvalid    (bus.s_axi_wvalid),
    .wready    (bus.s_axi_wready),
    .aw_full   (aw_full),
    .w_full    (w_full),
    .aw_addr_q (aw_addr_q),
    .w_data_q  (w_data_q),
    .w_strb_q  (w_strb_q)
  );

  assign idle       = (state == ST_IDLE);
  assign aw_take    = bus.s_axi_awvalid && bus.s_axi_awready;
  assign w_take     = bus.s_axi_wvalid && bus.s_axi_wready;
  // A write counts as complete if each half is either latched or arriving now.
  assign wr_req     = (aw_full || aw_take) && (w_full || w_take);
  assign ar_take    = bus.s_axi_arvalid && bus.s_axi_arready;
  assign hold_clear = (state == ST_WR_RESP) && bus.s_axi_bready;
  assign addr_ok    = slot_ok(addr_q[SLOT_MSB:SLOT_LSB], NUM_SLOTS);
  assign wr_legal   = addr_ok && (w_strb_q == 4'hF);

  assign bus.s_axi_arready = idle && !rst && !aw_full && !w_full && !(wr_req && last_rd);
  assign bus.s_axi_bvalid  = (state == ST_WR_RESP) && !rst;
  assign bus.s_axi_rvalid  = (state == ST_RD_RESP) && !rst;
  assign bus.sys_if_wen    = (state == ST_WR_ISSUE) && wr_legal && !rst;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.sys_if_addr   = addr_q;
  assign bus.sys_if_wdata  = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (ar_take)     state_n = ST_RD_WAIT;
        else if (wr_req) state_n = ST_WR_ISSUE;
      end
      ST_WR_ISSUE: state_n = ST_WR_RESP;
      ST_WR_RESP:  if (bus.s_axi_bready) state_n = ST_IDLE;
      ST_RD_WAIT:  if (cnt == 4'd0) state_n = ST_RD_RESP;
      ST_RD_RESP:  if (bus.s_axi_rready) state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // last_rd resets high so the first contested grant goes to the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd <= 1'b1;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_take) begin
            addr_q  <= bus.s_axi_araddr;
            cnt     <= 4'(RD_WAIT - 1);
            last_rd <= 1'b1;
          end else if (wr_req) begin
            addr_q  <= aw_full ? aw_addr_q : bus.s_axi_awaddr;
            wdata_q <= w_full ? w_data_q : bus.s_axi_wdata;
            last_rd <= 1'b0;
          end
        end
        ST_WR_ISSUE: begin
          if (!addr_ok)               bresp_q <= RESP_DECERR;
          else if (w_strb_q != 4'hF)  bresp_q <= RESP_SLVERR;
          else                        bresp_q <= RESP_OKAY;
        end
        ST_RD_WAIT: begin
          if (cnt == 4'd0) begin
            rdata_q <= addr_ok ? bus.sys_if_rdata : 32'h0;
            rresp_q <= addr_ok ? RESP_OKAY : RESP_DECERR;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
